// File: rtl/hazard_pkg.sv
// Shared constants, MD timer state type and the RAW hazard helper for hazard_stall_ctrl.
// The optional HAZARD_PERF_CNT_EN feature lives entirely in the top-level module.
package hazard_pkg;

  localparam int T_WIDTH         = 2;
  localparam int CNT_WIDTH       = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [T_WIDTH-1:0] TUSE_NONE = 2'd3;
  localparam logic [4:0]         REG_ZERO  = 5'd0;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_e;

  // A D-stage operand must wait when a producer will not have its value forwardable
  // by the time the operand is consumed (Tnew > Tuse).
  function automatic logic raw_hazard(
    input logic [4:0]         addr,
    input logic [T_WIDTH-1:0] tuse,
    input logic [4:0]         e_wa,
    input logic [T_WIDTH-1:0] e_tnew,
    input logic [4:0]         m_wa,
    input logic [T_WIDTH-1:0] m_tnew
  );
    return (addr != REG_ZERO) && (tuse != TUSE_NONE) &&
           (((e_wa == addr) && (e_tnew > tuse)) ||
            ((m_wa == addr) && (m_tnew > tuse)));
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy timer: loads the operation latency on a start pulse and reports
// busy for that many cycles, followed by a one-cycle done pulse.
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic md_busy,
  output logic md_done
);

  md_state_e            state;
  logic [CNT_WIDTH-1:0] cnt;

  // A start while busy is dropped; the running count is never restarted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            cnt     <= is_div ? CNT_WIDTH'(DIV_CYCLES) : CNT_WIDTH'(MULT_CYCLES);
            state   <= MD_BUSY;
            md_busy <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt == CNT_WIDTH'(1)) begin
            cnt     <= '0;
            state   <= MD_IDLE;
            md_busy <= 1'b0;
            md_done <= 1'b1;
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        default: begin
          state   <= MD_IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

  // A second mult/div reaching E while the unit is busy means the pipeline failed to stall it.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset)
    !((state == MD_BUSY) && start))
    else $error("md_busy_timer: e_md_start while busy");

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central hazard scheduler: Tuse/Tnew RAW stalls, mult/div busy stalls, PC/FD/DE control.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / md_stall_cycles performance counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         d_rs_addr,
  input  logic [4:0]         d_rt_addr,
  input  logic [T_WIDTH-1:0] d_rs_tuse,
  input  logic [T_WIDTH-1:0] d_rt_tuse,
  input  logic               d_is_md,
  input  logic [4:0]         e_wa,
  input  logic [T_WIDTH-1:0] e_tnew,
  input  logic [4:0]         m_wa,
  input  logic [T_WIDTH-1:0] m_tnew,
  input  logic               e_md_start,
  input  logic               e_md_is_div,
  output logic               stall,
  output logic               pc_en,
  output logic               fd_en,
  output logic               de_clr,
  output logic               md_busy,
  output logic               md_done
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        md_stall_cycles
`endif
);

  logic rs_stall;
  logic rt_stall;
  logic md_stall;

  md_busy_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_is_div),
    .md_busy(md_busy),
    .md_done(md_done)
  );

  // The start pulse counts as busy so an mfhi/mflo right behind a mult/div is held at once.
  always_comb begin
    rs_stall = raw_hazard(d_rs_addr, d_rs_tuse, e_wa, e_tnew, m_wa, m_tnew);
    rt_stall = raw_hazard(d_rt_addr, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew);
    md_stall = d_is_md && (md_busy || e_md_start);
    stall    = !reset && (rs_stall || rt_stall || md_stall);
    pc_en    = !stall;
    fd_en    = !stall;
    de_clr   = stall;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters; they hold at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles    <= '0;
      md_stall_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (md_stall && (md_stall_cycles != '1)) begin
        md_stall_cycles <= md_stall_cycles + 32'd1;
      end
    end
  end
`else
  // Without the counters md_stall only feeds the stall output above.
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Central hazard scheduler for the 5-stage MIPS pipeline. It compares the D-stage operand needs (Tuse) against the E/M-stage producers (Tnew), and runs the mult/div busy timer. It drives the PC and F/D register enables and the D/E bubble insert.
The E/M and M/W pipeline registers always advance; only PC, F/D and D/E are controlled here.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
d_rs_addr  in  5  D-stage rs index
d_rt_addr  in  5  D-stage rt index
d_rs_tuse  in  2  cycles until rs is consumed; 3 = not used
d_rt_tuse  in  2  same for rt
d_is_md  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
e_wa  in  5  E-stage destination register (0 = none)
e_tnew  in  2  cycles until E result is forwardable
m_wa  in  5  M-stage destination register
m_tnew  in  2  same for M
e_md_start  in  1  mult/div in E this cycle (one-cycle pulse)
e_md_is_div  in  1  qualifies e_md_start: 1 = div, 0 = mult
stall  out  1  D-stage hold
pc_en  out  1  PC write enable
fd_en  out  1  F/D register enable
de_clr  out  1  D/E register clear (bubble)
md_busy  out  1  mult/div unit busy (registered)
md_done  out  1  one-cycle pulse when busy drops (registered)

Behaviour:
- Reset: clk and reset (synchronous, active-high) are already decided.
  - While reset is high: md_busy=0, md_done=0, internal counter=0.
  - stall is forced 0, so pc_en=1, fd_en=1, de_clr=0.
- RAW stall (combinational):
  - rs_stall = (d_rs_addr!=0) && ((e_wa==d_rs_addr && e_tnew>d_rs_tuse) || (m_wa==d_rs_addr && m_tnew>d_rs_tuse)).
  - rt_stall is the same check for rt.
  - Tuse=3 never stalls.
  - Register 0 never stalls.
- MD stall (combinational): md_stall = d_is_md && (md_busy || e_md_start).
- stall = ~reset && (rs_stall || rt_stall || md_stall); pc_en = fd_en = ~stall; de_clr = stall.
  - Zero-cycle latency: the stall applies in the same cycle the hazard is visible.
- MD timer, 4-bit down-counter, states IDLE / BUSY:
  - IDLE + e_md_start: load cnt = e_md_is_div ? DIV_CYCLES : MULT_CYCLES, go BUSY.
  - BUSY: md_busy=1; cnt decrements each cycle.
  - BUSY with cnt==1: next cycle → IDLE, md_busy=0, md_done=1 for exactly one cycle.
- With a start pulse at cycle t, md_busy is high for cycles t+1..t+N and md_done pulses at t+N+1.
- e_md_start while BUSY is ignored (the count is not restarted). A simulation assertion flags it as a pipeline bug.
- md_done and a new e_md_start in the same cycle: a legal back-to-back start; the timer reloads.
- Reset mid-operation aborts the count immediately; no md_done is emitted.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] and md_stall_cycles[31:0].
  - stall_cycles increments on every cycle with stall=1.
  - md_stall_cycles increments when md_stall=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - TUSE_NONE=2'd3
  - REG_ZERO=5'd0
  - default MULT_CYCLES/DIV_CYCLES
  - tuse/tnew width constant (2)
  - an MD state enum (IDLE, BUSY).
- Natural sub-module md_busy_timer: the counter, FSM, md_busy and md_done.
- Top-level keeps the compare logic and the perf counters.

Test Plan:
- Load-use: e_wa=8, e_tnew=2, d_rs_addr=8, d_rs_tuse=1 → stall=1, pc_en=0, de_clr=1. Next cycle with e_tnew=1 (same reg in M, m_tnew=1) → stall=0.
- Zero/unused operands: e_wa=0, d_rs_addr=0, e_tnew=2 → stall=0; d_rt_tuse=3 with m_wa==d_rt_addr, m_tnew=2 → stall=0.
- Mult timing: e_md_start=1, e_md_is_div=0 at t → md_busy high t+1..t+5, md_done=1 at t+6 only. mflo held in D (d_is_md=1) stalls from t through t+5.
- Div back-to-back: div at t, second start pulsed at t+3 (ignored, assertion fires) → busy still ends after 10 cycles. A new mult at the md_done cycle reloads 5.
- Reset mid-div: reset at t+4 of a div → md_busy=0 and stall=0 the next cycle, md_done never pulses.
- Perf (HAZARD_PERF_CNT_EN): 7 stall cycles, 5 of them md → stall_cycles=7, md_stall_cycles=5; after reset both read 0.
